codec_cfg_sequencer: RTL and testbench
======================================

// Module: codec_cfg_sequencer
// PURPOSE
//  Power-up/configuration sequencer for the WM8731-class audio codec. Walks an internal table of
//  {7-bit reg, 9-bit data} words and hands each one to the byte-level I2C master over a valid/ready
//  command handshake. Retries NACKed writes. Asserts audio_en, which gates the I2S controller and
//  the tone path, only after the full table has been acknowledged. Runs in the slow_clk domain.
// PARAMETERS
//  NUM_REGS     10         table entries; entry 0 is the codec reset write (R15 <= 0)
//  GAP_CYCLES   16'd1200   idle clk cycles after each acked write (~100 us at 12 MHz)
//  RESET_WAIT   16'd12000  extra idle cycles after entry 0 (codec reset settle)
//  MAX_RETRY    2          NACK retries per entry; total attempts = MAX_RETRY+1
// PORTS
//  clk          in   1   slow_clk (12 MHz)
//  reset        in   1   asynchronous, active-high
//  start        in   1   1-cycle pulse; begins/restarts the sequence from IDLE, DONE or ERROR
//  cmd_valid    out  1   command to I2C master valid
//  cmd_ready    in   1   I2C master can accept a command
//  cmd_word     out  16  {reg[6:0], data[8:0]} as sent MSB-first
//  cmd_done     in   1   1-cycle pulse: transfer finished
//  cmd_nack     in   1   qualifies cmd_done: 1 = any byte NACKed
//  busy         out  1   sequence in progress
//  audio_en     out  1   config complete and all writes acked
//  init_err     out  1   sticky: an entry exhausted its retries
//  state_info   out  4   current state code, drives the seven-segment display
//  entry_idx    out  4   index of the current/last entry
// BEHAVIOUR
//  Reset: state=IDLE; cmd_valid=0, cmd_word=0, busy=0, audio_en=0, init_err=0, entry_idx=0,
//    retry count=0, gap counter=0.
//  States (state_info code): IDLE(0) ISSUE(1) WAIT(2) GAP(3) DONE(4) ERROR(5).
//  IDLE: start -> ISSUE; entry_idx=0; retry count=0; clear audio_en and init_err. busy=1 in all
//    states other than IDLE, DONE and ERROR.
//  ISSUE: cmd_valid=1, cmd_word=table[entry_idx]. Both stay stable until cmd_valid&cmd_ready is
//    sampled high. On that edge cmd_valid drops and the state goes to WAIT, so the pair holds for
//    exactly one transfer.
//  WAIT: wait for cmd_done. Responses:
//    ack (nack=0): load the gap counter with GAP_CYCLES, plus RESET_WAIT when entry_idx==0,
//      then go to GAP.
//    nack with retries < MAX_RETRY: increment the retry count and go to ISSUE on the next cycle
//      with the same entry.
//    nack with retries == MAX_RETRY: set init_err and go to ERROR.
//  GAP: decrement the counter each cycle. When it reaches 0:
//    entry_idx == NUM_REGS-1: go to DONE.
//    otherwise: entry_idx+1, retry count=0, go to ISSUE.
//    Gap length is exactly the loaded count; a loaded count of 0 leaves GAP on the next cycle.
//  DONE: audio_en=1 (registered, asserted the cycle DONE is entered) and held.
//  ERROR: audio_en=0, init_err=1, both held.
//  start outside IDLE/DONE/ERROR is ignored. No restart mid-transfer; the I2C bus must not be
//    abandoned. start in DONE or ERROR acts as it does in IDLE.
//  Simultaneous events:
//    cmd_done in ISSUE: ignored (spurious).
//    cmd_ready high with cmd_valid low: no effect.
//  Asynchronous reset mid-transfer: all outputs return to reset values at once. The I2C master
//    is reset by the same signal.
//  Widths: the gap counter is 17 bits (GAP_CYCLES+RESET_WAIT must not overflow); entry_idx
//    saturates at NUM_REGS-1.
//  Latency: start to first cmd_valid = 1 cycle. Handshake to next cmd_valid, ack case:
//    1 (WAIT) + transfer time + gap + 1.
// STRUCTURE
//  synth_pkg:
//    WM8731 register address localparams (LLIN, RLIN, LHP, RHP, AAPC, DAPC, PDC, DAIF, SRC,
//      ACT, RESET)
//    state codes for state_info
//    cmd_word packing function {reg, data}
//  Sub-module codec_cfg_rom: combinational, index[3:0] -> word[15:0]. Holds the default table:
//    RESET, PDC, LHP, RHP, AAPC, DAPC, DAIF(16-bit I2S), SRC(48k), LLIN, ACT=1.
//    Unused indices return 16'h0000.
//  The sequencer holds only the FSM, counters and handshake logic.
// TESTING (GAP_CYCLES=4, RESET_WAIT=8, NUM_REGS=10, MAX_RETRY=2, BFM master)
//  1. Happy path. Reset, pulse start, cmd_ready=1, every write acks done after 20 cycles.
//     Expect: 10 words in ROM order, word0=16'h1E00; GAP of 12 cycles after entry 0 and 4 after
//     each other entry; audio_en rises with DONE; init_err=0.
//  2. Backpressure. Hold cmd_ready=0 for 7 cycles in ISSUE.
//     Expect: cmd_valid and cmd_word stable throughout, exactly one accept.
//  3. Single NACK. NACK entry 3 once.
//     Expect: word3 reissued with identical cmd_word, no GAP between the attempts; sequence
//     then completes with audio_en=1.
//  4. Retries exhausted. NACK entry 5 three times.
//     Expect: ERROR, init_err=1, audio_en=0, entry_idx=5, no further cmd_valid. A following
//     start restarts at entry 0 with init_err cleared.
//  5. Reset mid-transfer. Assert reset in WAIT of entry 2.
//     Expect: all outputs at reset values during reset. Extra start pulses sent in WAIT/GAP
//     are ignored (word count unchanged).
//  6. Spurious done. Pulse cmd_done while in ISSUE.
//     Expect: no state change.

Source files
------------

// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: register map,
// state codes shown on the display and command word packing.
package codec_cfg_sequencer_pkg;

  localparam int unsigned REG_W  = 7;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned WORD_W = REG_W + DATA_W;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned GAP_W  = 17;

  localparam logic [REG_W-1:0] REG_LLIN  = 7'h00;
  localparam logic [REG_W-1:0] REG_RLIN  = 7'h01;
  localparam logic [REG_W-1:0] REG_LHP   = 7'h02;
  localparam logic [REG_W-1:0] REG_RHP   = 7'h03;
  localparam logic [REG_W-1:0] REG_AAPC  = 7'h04;
  localparam logic [REG_W-1:0] REG_DAPC  = 7'h05;
  localparam logic [REG_W-1:0] REG_PDC   = 7'h06;
  localparam logic [REG_W-1:0] REG_DAIF  = 7'h07;
  localparam logic [REG_W-1:0] REG_SRC   = 7'h08;
  localparam logic [REG_W-1:0] REG_ACT   = 7'h09;
  localparam logic [REG_W-1:0] REG_RESET = 7'h0F;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_WAIT  = 4'd2,
    ST_GAP   = 4'd3,
    ST_DONE  = 4'd4,
    ST_ERROR = 4'd5
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

  // Register address goes out first on the wire, so it occupies the MSBs.
  function automatic cmd_word_t pack_cmd(input logic [REG_W-1:0]  addr,
                                         input logic [DATA_W-1:0] data);
    cmd_word_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_rom.sv
// Default WM8731 power-up table: codec reset first, activate last.
module codec_cfg_rom
  import codec_cfg_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_idx)
      IDX_W'(0): o_word = pack_cmd(REG_RESET, 9'h000);
      IDX_W'(1): o_word = pack_cmd(REG_PDC,   9'h002);
      IDX_W'(2): o_word = pack_cmd(REG_LHP,   9'h079);
      IDX_W'(3): o_word = pack_cmd(REG_RHP,   9'h079);
      IDX_W'(4): o_word = pack_cmd(REG_AAPC,  9'h012);
      IDX_W'(5): o_word = pack_cmd(REG_DAPC,  9'h000);
      IDX_W'(6): o_word = pack_cmd(REG_DAIF,  9'h002);  // I2S, 16-bit
      IDX_W'(7): o_word = pack_cmd(REG_SRC,   9'h000);  // 48 kHz normal mode
      IDX_W'(8): o_word = pack_cmd(REG_LLIN,  9'h017);
      IDX_W'(9): o_word = pack_cmd(REG_ACT,   9'h001);
      default:   o_word = '0;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: issues each ROM word to the I2C master,
// retries NACKs, paces writes and enables audio once every write is acked.
module codec_cfg_sequencer
  import codec_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 10,
  parameter logic [15:0] GAP_CYCLES = 16'd1200,
  parameter logic [15:0] RESET_WAIT = 16'd12000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [WORD_W-1:0] cmd_word,
  input  logic              cmd_done,
  input  logic              cmd_nack,
  output logic              busy,
  output logic              audio_en,
  output logic              init_err,
  output logic [3:0]        state_info,
  output logic [IDX_W-1:0]  entry_idx
);

  localparam int unsigned     RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_e              r_state;
  logic                r_cmd_valid;
  logic [WORD_W-1:0]   r_cmd_word;
  logic                r_busy;
  logic                r_audio_en;
  logic                r_init_err;
  logic [IDX_W-1:0]    r_entry_idx;
  logic [RETRY_W-1:0]  r_retry;
  logic [GAP_W-1:0]    r_gap;

  logic [IDX_W-1:0]    w_rom_idx;
  logic [WORD_W-1:0]   w_rom_word;

  // Only two lookups are ever needed: entry 0 on start, the next entry on leaving GAP.
  assign w_rom_idx = (r_state == ST_GAP) ? IDX_W'(r_entry_idx + IDX_W'(1)) : '0;

  codec_cfg_rom u_rom (
    .i_idx  (w_rom_idx),
    .o_word (w_rom_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_word  <= '0;
      r_busy      <= 1'b0;
      r_audio_en  <= 1'b0;
      r_init_err  <= 1'b0;
      r_entry_idx <= '0;
      r_retry     <= '0;
      r_gap       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state     <= ST_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_word  <= w_rom_word;
            r_busy      <= 1'b1;
            r_audio_en  <= 1'b0;
            r_init_err  <= 1'b0;
            r_entry_idx <= '0;
            r_retry     <= '0;
            r_gap       <= '0;
          end
        end
        ST_ISSUE: begin
          if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd_done) begin
            if (!cmd_nack) begin
              r_gap   <= (r_entry_idx == '0) ? GAP_W'(GAP_CYCLES) + GAP_W'(RESET_WAIT)
                                             : GAP_W'(GAP_CYCLES);
              r_state <= ST_GAP;
            end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
              // Word register still holds this entry, so the reissue is identical.
              r_retry     <= RETRY_W'(r_retry + RETRY_W'(1));
              r_cmd_valid <= 1'b1;
              r_state     <= ST_ISSUE;
            end else begin
              r_init_err <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_ERROR;
            end
          end
        end
        ST_GAP: begin
          // GAP occupies exactly the loaded count of cycles (at least one).
          if (r_gap <= GAP_W'(1)) begin
            r_gap <= '0;
            if (r_entry_idx == LAST_IDX) begin
              r_busy     <= 1'b0;
              r_audio_en <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_entry_idx <= IDX_W'(r_entry_idx + IDX_W'(1));
              r_retry     <= '0;
              r_cmd_word  <= w_rom_word;
              r_cmd_valid <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end else begin
            r_gap <= GAP_W'(r_gap - GAP_W'(1));
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_word   = r_cmd_word;
  assign busy       = r_busy;
  assign audio_en   = r_audio_en;
  assign init_err   = r_init_err;
  assign state_info = r_state;
  assign entry_idx  = r_entry_idx;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: I2C master BFM plus a transaction-level model
// of which words must be issued, how long each gap lasts and how the run ends.
module tb_codec_cfg_sequencer;

  localparam int GAP  = 4;
  localparam int RW   = 8;
  localparam int NREG = 10;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        reset, start, cmd_ready, cmd_done, cmd_nack;
  logic        cmd_valid, busy, audio_en, init_err;
  logic [15:0] cmd_word;
  logic [3:0]  state_info, entry_idx;

  always #5 clk = ~clk;

  codec_cfg_sequencer #(
    .NUM_REGS   (NREG),
    .GAP_CYCLES (16'd4),
    .RESET_WAIT (16'd8),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_word   (cmd_word),
    .cmd_done   (cmd_done),
    .cmd_nack   (cmd_nack),
    .busy       (busy),
    .audio_en   (audio_en),
    .init_err   (init_err),
    .state_info (state_info),
    .entry_idx  (entry_idx)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // WM8731 default table as {register number, 9-bit data}.
  int unsigned exp_reg[NREG] = '{15, 6, 2, 3, 4, 5, 7, 8, 0, 9};
  int unsigned exp_dat[NREG] = '{0, 2, 'h79, 'h79, 'h12, 0, 2, 0, 'h17, 1};

  function automatic logic [15:0] exp_word(input int e);
    return 16'(exp_reg[e] * 512 + exp_dat[e]);
  endfunction

  // Per-run BFM configuration and observations
  int          nack_plan[NREG];
  int          stall_per;
  int          done_delay;
  bit          inject_start;
  int          stop_wait_idx;
  logic [15:0] issued_q[$];
  int          gap_cnt[NREG];
  int          stable_err;

  // Cycle-level I2C master: accepts after stall_per cycles, reports done after done_delay.
  task automatic run_sequence(input int budget);
    int          att[NREG];
    int          stall_left;
    int          countdown;
    int          fl_idx;
    logic [15:0] held;
    bit          holding;
    issued_q.delete();
    for (int e = 0; e < NREG; e++) begin att[e] = 0; gap_cnt[e] = 0; end
    stable_err = 0;
    countdown  = -1;
    fl_idx     = 0;
    held       = '0;
    stall_left = stall_per;
    holding    = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (state_info == 4'd3 && entry_idx < NREG) gap_cnt[entry_idx]++;
      if (stop_wait_idx >= 0 && state_info == 4'd2 && int'(entry_idx) == stop_wait_idx) return;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          cmd_done  = 1'b1;
          cmd_nack  = (att[fl_idx] < nack_plan[fl_idx]);
          att[fl_idx]++;
          countdown = -1;
        end
      end
      if (cmd_valid) begin
        if (holding && cmd_word !== held) stable_err++;
        holding = 1'b1;
        held    = cmd_word;
        if (stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
        end else begin
          cmd_ready = 1'b1;
          issued_q.push_back(cmd_word);
          fl_idx     = int'(entry_idx);
          countdown  = done_delay;
          stall_left = stall_per;
          holding    = 1'b0;
        end
      end else begin
        if (holding) stable_err++;
        holding   = 1'b0;
        cmd_ready = 1'($urandom_range(0, 1));
      end
      if (inject_start && (state_info == 4'd2 || state_info == 4'd3) && $urandom_range(0, 7) == 0)
        start = 1'b1;
      if (countdown < 0 && !cmd_done && (state_info == 4'd4 || state_info == 4'd5)) return;
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start     = 1'b1;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_valid"}, cmd_valid, 1);
    chk({tag, "_start_state"}, state_info, 1);
    chk({tag, "_start_idx"}, entry_idx, 0);
    chk({tag, "_start_err"}, init_err, 0);
    chk({tag, "_start_aen"}, audio_en, 0);
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_word"}, cmd_word, 16'h1E00);
  endtask

  // Model: each entry takes nacks+1 attempts; more than MAXR nacks ends the run in error.
  task automatic check_run(input string tag);
    logic [15:0] exp_q[$];
    int exp_gap[NREG];
    bit err;
    int last;
    int n_cmp;
    int v;
    err  = 1'b0;
    last = NREG - 1;
    for (int e = 0; e < NREG; e++) exp_gap[e] = 0;
    for (int e = 0; e < NREG && !err; e++) begin
      int n = nack_plan[e];
      int tries = (n > MAXR) ? MAXR + 1 : n + 1;
      repeat (tries) exp_q.push_back(exp_word(e));
      if (n > MAXR) begin err = 1'b1; last = e; end
      else exp_gap[e] = GAP + ((e == 0) ? RW : 0);
    end
    chk({tag, "_count"}, issued_q.size(), exp_q.size());
    n_cmp = (issued_q.size() < exp_q.size()) ? issued_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      chk($sformatf("%s_word%0d", tag, i), issued_q[i], exp_q[i]);
    for (int e = 0; e < NREG; e++)
      chk($sformatf("%s_gap%0d", tag, e), gap_cnt[e], exp_gap[e]);
    chk({tag, "_aen"}, audio_en, !err);
    chk({tag, "_err"}, init_err, err);
    chk({tag, "_idx"}, entry_idx, last);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state_info, err ? 5 : 4);
    chk({tag, "_stable"}, stable_err, 0);
    v = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid) v++;
    end
    chk({tag, "_quiet"}, v, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_word"}, cmd_word, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_aen"}, audio_en, 0);
    chk({tag, "_err"}, init_err, 0);
    chk({tag, "_state"}, state_info, 0);
    chk({tag, "_idx"}, entry_idx, 0);
  endtask

  typedef struct {
    int nack_e;
    int nack_n;
    int stall;
    int delay;
    bit inj;
    bit exp_err;
    int exp_idx;
    bit exp_aen;
  } scen_t;

  scen_t tbl[5];

  initial begin
    tbl[0] = '{-1, 0, 0, 20, 1'b0, 1'b0, 9, 1'b1};  // happy path
    tbl[1] = '{-1, 0, 7, 5,  1'b0, 1'b0, 9, 1'b1};  // backpressure
    tbl[2] = '{ 3, 1, 0, 3,  1'b0, 1'b0, 9, 1'b1};  // single NACK
    tbl[3] = '{ 5, 3, 1, 2,  1'b0, 1'b1, 5, 1'b0};  // retries exhausted
    tbl[4] = '{-1, 0, 0, 2,  1'b1, 1'b0, 9, 1'b1};  // restart after error, ignored starts

    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
    stop_wait_idx = -1; inject_start = 1'b0; stall_per = 0; done_delay = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold_state", state_info, 0);

    for (int i = 0; i < 5; i++) begin
      string tag = $sformatf("vec%0d", i);
      for (int e = 0; e < NREG; e++) nack_plan[e] = 0;
      if (tbl[i].nack_e >= 0) nack_plan[tbl[i].nack_e] = tbl[i].nack_n;
      stall_per = tbl[i].stall; done_delay = tbl[i].delay; inject_start = tbl[i].inj;
      do_start(tag);
      run_sequence(3000);
      chk({tag, "_tbl_aen"}, audio_en, tbl[i].exp_aen);
      chk({tag, "_tbl_err"}, init_err, tbl[i].exp_err);
      chk({tag, "_tbl_idx"}, entry_idx, tbl[i].exp_idx);
      check_run(tag);
    end

    // Spurious done while the command is still pending
    inject_start = 1'b0; stall_per = 0; done_delay = 2;
    for (int e = 0; e < NREG; e++) nack_plan[e] = 0;
    do_start("spur");
    cmd_done = 1'b1; cmd_nack = 1'b0;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("spur_state", state_info, 1);
    chk("spur_valid", cmd_valid, 1);
    chk("spur_word", cmd_word, 16'h1E00);
    run_sequence(3000);
    check_run("spur");

    // Reset while entry 2 is in flight, with stray starts during WAIT/GAP
    inject_start = 1'b1; stop_wait_idx = 2; done_delay = 6;
    do_start("rmid");
    run_sequence(3000);
    chk("rmid_state", state_info, 2);
    chk("rmid_idx", entry_idx, 2);
    chk("rmid_count", issued_q.size(), 3);
    reset = 1'b1; start = 1'b0; cmd_done = 1'b0;
    #1;
    check_reset_vals("rmid_rst");
    @(negedge clk);
    reset = 1'b0;
    stop_wait_idx = -1; inject_start = 1'b0;
    @(negedge clk);
    chk("rmid_post_state", state_info, 0);

    // Randomized NACK patterns, stalls and transfer times
    for (int r = 0; r < 8; r++) begin
      string tag = $sformatf("rnd%0d", r);
      for (int e = 0; e < NREG; e++) begin
        int u = int'($urandom_range(0, 19));
        nack_plan[e] = (u < 14) ? 0 : (u < 17) ? 1 : (u < 19) ? 2 : 3;
      end
      stall_per    = int'($urandom_range(0, 3));
      done_delay   = int'($urandom_range(1, 6));
      inject_start = 1'($urandom_range(0, 1));
      do_start(tag);
      run_sequence(4000);
      check_run(tag);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
